ex_stage: RTL

- Execute stage of the 5-stage in-order pipeline, between the ID stage and the MEM stage.
- Computes the ALU result, or a multiply/divide result, from the operands ID has already registered.
- Repacks the instruction into the 145-bit EX-to-MEM bus and passes the exception bundle through.
- Single-cycle for ALU and multiply ops; divide and modulo use an iterative multi-cycle divider that stalls the stage.

---
 rtl/ex_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU, multiplier, iterative divider when EX_DIV_EN is defined)
module ex_stage #(
  parameter int XLEN = 32
`ifdef EX_DIV_EN
  , parameter int DIV_CYCLES = 32
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         MEM_allowin,
  input  logic [181:0] ID_to_EX_zip,
  input  logic [96:0]  ID_except_zip,
  output logic         EX_allowin,
  output logic         front_valid,
  output logic         front_ready,
  output logic [4:0]   front_addr,
  output logic [31:0]  front_data,
  output logic         ex_is_load,
  output logic [144:0] EX_to_MEM_reg,
  output logic [96:0]  EX_except_reg
);
  logic            valid;
  logic [31:0]     pc, ir, rkd_value;
  logic [4:0]      alu_op, rf_waddr;
  logic [XLEN-1:0] src1, src2, alu_res, result;
  logic [10:0]     mem_flags;
  logic [2*XLEN-1:0] prod;
  logic            mul_sgn, readygo;
  assign {valid, pc, ir, alu_op, src1, src2, mem_flags, rkd_value, rf_waddr} = ID_to_EX_zip;
  assign mul_sgn = alu_op == 5'd13;
  assign prod = {{XLEN{mul_sgn & src1[XLEN-1]}}, src1} * {{XLEN{mul_sgn & src2[XLEN-1]}}, src2};
  // single-cycle ALU and multiplier result select
  always_comb begin
    alu_res = '0;
    case (alu_op)
      5'd0:  alu_res = src1 + src2;
      5'd1:  alu_res = src1 - src2;
      5'd2:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      5'd3:  alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      5'd4:  alu_res = src1 & src2;
      5'd5:  alu_res = src1 | src2;
      5'd6:  alu_res = ~(src1 | src2);
      5'd7:  alu_res = src1 ^ src2;
      5'd8:  alu_res = src1 << src2[4:0];
      5'd9:  alu_res = src1 >> src2[4:0];
      5'd10: alu_res = $signed(src1) >>> src2[4:0];
      5'd11: alu_res = src2;
      5'd12: alu_res = prod[XLEN-1:0];
      5'd13, 5'd14: alu_res = prod[2*XLEN-1:XLEN];
      default: alu_res = '0;
    endcase
  end
`ifdef EX_DIV_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  div_state_t      div_state;
  logic            is_div, sgn_op, neg_q, neg_r, want_rem;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dvs, abs1, abs2, div_res;
  logic [XLEN:0]   rem_sh, diff;
  assign is_div = alu_op inside {[5'd15:5'd18]};
  assign sgn_op = alu_op == 5'd15 || alu_op == 5'd16;
  assign abs1 = sgn_op & src1[XLEN-1] ? -src1 : src1;
  assign abs2 = sgn_op & src2[XLEN-1] ? -src2 : src2;
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff = rem_sh - {1'b0, dvs};
  assign div_res = want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  assign readygo = valid & (~is_div | div_state == DONE);
  assign result = is_div ? div_res : alu_res;
  // restoring divider: one quotient bit per BUSY cycle, sign fix-up applied on the DONE output
  always_ff @(posedge clk) begin
    if (rst || flush) div_state <= IDLE;
    else case (div_state)
      IDLE: if (valid && is_div) begin
        div_state <= BUSY;
        quo <= abs1;
        dvs <= abs2;
        rem <= '0;
        cnt <= '0;
        neg_q <= sgn_op & (src1[XLEN-1] ^ src2[XLEN-1]) & |src2;
        neg_r <= sgn_op & src1[XLEN-1];
        want_rem <= alu_op == 5'd16 || alu_op == 5'd18;
      end
      BUSY: begin
        quo <= {quo[XLEN-2:0], ~diff[XLEN]};
        rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DIV_CYCLES - 1)) div_state <= DONE;
      end
      DONE: if (readygo && MEM_allowin) div_state <= IDLE;
      default: div_state <= IDLE;
    endcase
  end
`else
  assign readygo = valid;
  assign result = alu_res;
`endif
  assign EX_allowin = ~valid | (readygo & MEM_allowin);
  assign front_valid = valid & mem_flags[0] & ~mem_flags[1];
  assign front_ready = readygo;
  assign front_addr = rf_waddr;
  assign front_data = result;
  assign ex_is_load = valid & mem_flags[1];
  // EX/MEM pipeline registers: flush clears, a stalled-but-accepting MEM receives a bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      EX_to_MEM_reg <= '0;
      EX_except_reg <= '0;
    end else if (MEM_allowin) begin
      EX_to_MEM_reg <= readygo ? {1'b1, pc, ir, mem_flags, rkd_value, rf_waddr, result} : '0;
      EX_except_reg <= readygo ? ID_except_zip : '0;
    end
  end
endmodule
